// File: rtl/cmsdk_apb3_eg_slave_fifo_reg_pkg.sv
// ----------------------------------------------------------------------------
// cmsdk_apb3_eg_slave_fifo_reg_pkg
//
// Shared definitions for the APB3 example-slave FIFO register block:
//   - byte offsets of every register in the map (DATA, STATUS, CTRL, THRESH,
//     and the optional ID0..ID3 block)
//   - bit positions inside STATUS and CTRL
//   - the constant values returned by the ID registers
//
// The ID registers only exist when CMSDK_APB3_EG_ID_REGS_EN is defined. Their
// offsets and values live here unconditionally so every build sees one map.
// ----------------------------------------------------------------------------
package cmsdk_apb3_eg_slave_fifo_reg_pkg;

    // Register byte offsets (12-bit map)
    localparam logic [11:0] ADDR_DATA   = 12'h000;
    localparam logic [11:0] ADDR_STATUS = 12'h004;
    localparam logic [11:0] ADDR_CTRL   = 12'h008;
    localparam logic [11:0] ADDR_THRESH = 12'h00C;
    localparam logic [11:0] ADDR_ID0    = 12'hFE0;
    localparam logic [11:0] ADDR_ID1    = 12'hFE4;
    localparam logic [11:0] ADDR_ID2    = 12'hFE8;
    localparam logic [11:0] ADDR_ID3    = 12'hFEC;

    // STATUS bit positions
    localparam int STATUS_EMPTY_BIT     = 0;
    localparam int STATUS_FULL_BIT      = 1;
    localparam int STATUS_OVERFLOW_BIT  = 2;
    localparam int STATUS_UNDERFLOW_BIT = 3;
    localparam int STATUS_COUNT_LSB     = 8;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    // ID register contents
    localparam logic [31:0] ID0_VALUE = 32'h0000_0080;
    localparam logic [31:0] ID1_VALUE = 32'h0000_00B8;
    localparam logic [31:0] ID2_VALUE = 32'h0000_001B;
    localparam logic [31:0] ID3_VALUE = 32'h0000_0000;

endpackage

// File: rtl/cmsdk_apb3_eg_slave_fifo_reg_sync_fifo.sv
// ----------------------------------------------------------------------------
// cmsdk_apb3_eg_sync_fifo
//
// Single-clock FIFO with push, pop and flush. The head word is presented
// combinationally on rdata. Pointers wrap modulo the depth, and count runs
// 0..DEPTH. A push while full or a pop while empty is ignored here; the
// register block above decides which of those become sticky error flags.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   push   in   write wdata at the tail
//   pop    in   drop the head word
//   flush  in   empty the FIFO this cycle (has priority over push/pop)
//   wdata  in   WIDTH-bit data to push
//   rdata  out  head word (only meaningful when not empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored words, DEPTH_LOG2+1 bits
// ----------------------------------------------------------------------------
module cmsdk_apb3_eg_sync_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q,  count_d;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_q == cnt_t'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointer overflow is the intended modulo-depth wrap.
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/cmsdk_apb3_eg_slave_fifo_reg.sv
// ----------------------------------------------------------------------------
// cmsdk_apb3_eg_slave_fifo_reg
//
// Register block behind the APB3 example slave interface. It exposes a
// software FIFO (DATA), a STATUS word with sticky W1C error flags, a CTRL
// register (enable, irq_en, self-clearing flush), and a THRESH register that
// drives a registered level interrupt.
//
// Optional build macro: CMSDK_APB3_EG_ID_REGS_EN adds read-only ID registers
// at 0xFE0..0xFEC. Without the macro those offsets read 0.
//
// Ports:
//   pclk      in   clock
//   preset    in   synchronous active-high reset
//   addr      in   byte address; addr[1:0] ignored
//   read_en   in   high for the whole APB read (setup + access)
//   write_en  in   single-cycle write strobe
//   wdata     in   32-bit write data
//   rdata     out  registered read data, loaded on the first read_en cycle
//   irq       out  registered level interrupt
// ----------------------------------------------------------------------------
module cmsdk_apb3_eg_slave_fifo_reg
    import cmsdk_apb3_eg_slave_fifo_reg_pkg::*;
#(
    parameter int ADDRWIDTH       = 12,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic                 read_en,
    input  logic                 write_en,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 irq
);

    typedef logic [ADDRWIDTH-1:0] addr_t;

    logic                     read_en_d_q, read_en_d_d;
    logic [31:0]              rdata_q,     rdata_d;
    logic                     irq_q,       irq_d;
    logic                     enable_q,    enable_d;
    logic                     irq_en_q,    irq_en_d;
    logic [7:0]               thresh_q,    thresh_d;
    logic                     overflow_q,  overflow_d;
    logic                     underflow_q, underflow_d;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_flush;
    logic [31:0]              fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    addr_t                    word_addr;
    logic                     read_start;
    logic                     sel_data;
    logic                     sel_status;
    logic                     sel_ctrl;
    logic                     sel_thresh;
    logic [31:0]              status_word;
    logic [31:0]              count_ext;
    logic [31:0]              read_value;
    logic                     unused_addr_bits;

    assign unused_addr_bits = &{1'b0, addr[1:0]};

    assign word_addr  = {addr[ADDRWIDTH-1:2], 2'b00};
    assign sel_data   = (word_addr == addr_t'(ADDR_DATA));
    assign sel_status = (word_addr == addr_t'(ADDR_STATUS));
    assign sel_ctrl   = (word_addr == addr_t'(ADDR_CTRL));
    assign sel_thresh = (word_addr == addr_t'(ADDR_THRESH));

    // One pop per APB read: only the rising edge of read_en acts.
    assign read_start = read_en & ~read_en_d_q;

    cmsdk_apb3_eg_sync_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        count_ext   = 32'(fifo_count);
        status_word = '0;
        status_word[STATUS_EMPTY_BIT]     = fifo_empty;
        status_word[STATUS_FULL_BIT]      = fifo_full;
        status_word[STATUS_OVERFLOW_BIT]  = overflow_q;
        status_word[STATUS_UNDERFLOW_BIT] = underflow_q;
        status_word[STATUS_COUNT_LSB +: 8] = count_ext[7:0];
    end

    // Read mux; DATA returns 0 when disabled or empty.
    always_comb begin
        read_value = '0;
        if (sel_data) begin
            if (enable_q && !fifo_empty) begin
                read_value = fifo_rdata;
            end
        end else if (sel_status) begin
            read_value = status_word;
        end else if (sel_ctrl) begin
            read_value[CTRL_ENABLE_BIT] = enable_q;
            read_value[CTRL_IRQ_EN_BIT] = irq_en_q;
        end else if (sel_thresh) begin
            read_value[7:0] = thresh_q;
        end
`ifdef CMSDK_APB3_EG_ID_REGS_EN
        else if (word_addr == addr_t'(ADDR_ID0)) begin
            read_value = ID0_VALUE;
        end else if (word_addr == addr_t'(ADDR_ID1)) begin
            read_value = ID1_VALUE;
        end else if (word_addr == addr_t'(ADDR_ID2)) begin
            read_value = ID2_VALUE;
        end else if (word_addr == addr_t'(ADDR_ID3)) begin
            read_value = ID3_VALUE;
        end
`endif
    end

    always_comb begin
        read_en_d_d = read_en;
        rdata_d     = rdata_q;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        thresh_d    = thresh_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;

        if (read_start) begin
            rdata_d = read_value;
            if (sel_data && enable_q) begin
                if (fifo_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    fifo_pop = 1'b1;
                end
            end
        end

        if (write_en) begin
            if (sel_data) begin
                if (enable_q) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end else if (sel_status) begin
                if (wdata[STATUS_OVERFLOW_BIT]) begin
                    overflow_d = 1'b0;
                end
                if (wdata[STATUS_UNDERFLOW_BIT]) begin
                    underflow_d = 1'b0;
                end
            end else if (sel_ctrl) begin
                enable_d   = wdata[CTRL_ENABLE_BIT];
                irq_en_d   = wdata[CTRL_IRQ_EN_BIT];
                fifo_flush = wdata[CTRL_FLUSH_BIT];
            end else if (sel_thresh) begin
                thresh_d = wdata[7:0];
            end
        end

        // A threshold above the depth can never be met because count <= depth.
        irq_d = irq_en_q && (thresh_q != 8'd0) &&
                ({1'b0, count_ext[8:0]} >= {2'b00, thresh_q});
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            read_en_d_q <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            thresh_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            read_en_d_q <= read_en_d_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            thresh_q    <= thresh_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_cmsdk_apb3_eg_slave_fifo_reg.sv
// ----------------------------------------------------------------------------
// tb_cmsdk_apb3_eg_slave_fifo_reg
//
// Self-checking bench for the FIFO register block. Expected read data is
// queued when a read is issued and popped when the registered rdata is
// sampled. Inputs change and outputs are sampled on the falling edge of pclk.
// Honours CMSDK_APB3_EG_ID_REGS_EN to select the expected ID readback.
// ----------------------------------------------------------------------------
module tb_cmsdk_apb3_eg_slave_fifo_reg;

    logic        pclk;
    logic        preset;
    logic [11:0] addr;
    logic        read_en;
    logic        write_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int errors;
    int checks;

    logic [31:0] exp_q [$];

    cmsdk_apb3_eg_slave_fifo_reg #(
        .ADDRWIDTH       (12),
        .FIFO_DEPTH_LOG2 (3)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .addr     (addr),
        .read_en  (read_en),
        .write_en (write_en),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Single-cycle write strobe.
    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge pclk);
        addr     = a;
        wdata    = d;
        write_en = 1'b1;
        @(negedge pclk);
        write_en = 1'b0;
    endtask

    // read_en held for 'hold' cycles; first is rdata in the access phase,
    // last is rdata at the end of the hold, followed by one idle cycle.
    task automatic bus_read(input logic [11:0] a, input int hold,
                            output logic [31:0] first, output logic [31:0] last);
        @(negedge pclk);
        addr    = a;
        read_en = 1'b1;
        @(negedge pclk);
        first = rdata;
        for (int i = 1; i < hold; i++) begin
            @(negedge pclk);
        end
        last    = rdata;
        read_en = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        logic [31:0] f, l, e;
        @(negedge pclk);
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        exp_q.push_back(32'h0000_0001);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected %h", f, e);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] f, l, e;
        bus_write(12'h008, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            bus_write(12'h000, 32'hA5A5_0000 + 32'(i));
        end
        exp_q.push_back(32'h0000_0802);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL full_status: got %h expected %h", f, e);
        end
        bus_write(12'h000, 32'hDEAD_BEEF);
        exp_q.push_back(32'h0000_0806);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL overflow_status: got %h expected %h", f, e);
        end
    endtask

    task automatic test_drain_underflow();
        logic [31:0] f, l, e;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(32'hA5A5_0000 + 32'(i));
            bus_read(12'h000, 3, f, l);
            e = exp_q.pop_front();
            checks++;
            if (f !== e || l !== e) begin
                errors++;
                $display("[TB] FAIL drain_data[%0d]: got %h/%h expected %h", i, f, l, e);
            end
        end
        exp_q.push_back(32'h0);
        bus_read(12'h000, 3, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL underflow_data: got %h expected %h", f, e);
        end
        exp_q.push_back(32'h0000_000D);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL underflow_status: got %h expected %h", f, e);
        end
    endtask

    task automatic test_w1c_flush();
        logic [31:0] f, l, e;
        bus_write(12'h004, 32'h0000_000C);
        exp_q.push_back(32'h0000_0001);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL w1c_status: got %h expected %h", f, e);
        end
        for (int i = 0; i < 3; i++) begin
            bus_write(12'h000, 32'h1234_0000 + 32'(i));
        end
        exp_q.push_back(32'h0000_0300);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL three_status: got %h expected %h", f, e);
        end
        bus_write(12'h008, 32'h5);
        exp_q.push_back(32'h0000_0001);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL flush_status: got %h expected %h", f, e);
        end
        exp_q.push_back(32'h0000_0001);
        bus_read(12'h008, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL flush_ctrl: got %h expected %h", f, e);
        end
    endtask

    task automatic test_disabled();
        logic [31:0] f, l, e;
        bus_write(12'h008, 32'h0);
        bus_write(12'h000, 32'h5555_AAAA);
        exp_q.push_back(32'h0);
        bus_read(12'h000, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL disabled_data: got %h expected %h", f, e);
        end
        exp_q.push_back(32'h0000_0001);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL disabled_status: got %h expected %h", f, e);
        end
    endtask

    task automatic test_threshold();
        logic [31:0] f, l, e;
        bus_write(12'h00C, 32'h4);
        exp_q.push_back(32'h0000_0004);
        bus_read(12'h00C, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL thresh_readback: got %h expected %h", f, e);
        end
        bus_write(12'h008, 32'h3);
        for (int i = 0; i < 3; i++) begin
            bus_write(12'h000, 32'hC0DE_0000 + 32'(i));
        end
        @(negedge pclk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_below: got %b expected 0", irq);
        end
        bus_write(12'h000, 32'hC0DE_0003);
        @(negedge pclk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_at_thresh: got %b expected 1", irq);
        end
        exp_q.push_back(32'hC0DE_0000);
        bus_read(12'h000, 1, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL thresh_pop: got %h expected %h", f, e);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_after_pop: got %b expected 0", irq);
        end
        bus_write(12'h00C, 32'h9);
        for (int i = 0; i < 5; i++) begin
            bus_write(12'h000, 32'hF00D_0000 + 32'(i));
        end
        @(negedge pclk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_thresh_gt_depth: got %b expected 0", irq);
        end
        bus_write(12'h00C, 32'h8);
        @(negedge pclk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_thresh_eq_depth: got %b expected 1", irq);
        end
    endtask

    task automatic test_id_unmapped();
        logic [31:0] f, l, e;
`ifdef CMSDK_APB3_EG_ID_REGS_EN
        exp_q.push_back(32'h0000_00B8);
`else
        exp_q.push_back(32'h0);
`endif
        bus_read(12'hFE4, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL id1_read: got %h expected %h", f, e);
        end
        exp_q.push_back(32'h0);
        bus_read(12'h010, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL unmapped_read: got %h expected %h", f, e);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] f, l, e;
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_irq: got %b expected 0", irq);
        end
        exp_q.push_back(32'h0000_0001);
        bus_read(12'h004, 2, f, l);
        e = exp_q.pop_front();
        checks++;
        if (f !== e) begin
            errors++;
            $display("[TB] FAIL midreset_status: got %h expected %h", f, e);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        preset   = 1'b1;
        addr     = '0;
        read_en  = 1'b0;
        write_en = 1'b0;
        wdata    = '0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_w1c_flush();
        test_disabled();
        test_threshold();
        test_id_unmapped();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmsdk_apb3_eg_slave_fifo_reg.md
Name: cmsdk_apb3_eg_slave_fifo_reg

Overview:
- Register block directly downstream of the APB3 example slave interface.
- Consumes the simple register protocol (addr/read_en/write_en/wdata) and returns rdata.
- Provides a software-accessible FIFO plus control, status and threshold registers, and raises a level-threshold interrupt.
- Sits between the APB interface stage and the peripheral's IRQ line on the APB subsystem.

Parameters:
- ADDRWIDTH, 12, register address width; matches the interface stage.
- FIFO_DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8); legal range 1..8.

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- addr  in  ADDRWIDTH  byte address; decode uses addr[ADDRWIDTH-1:2], addr[1:0] ignored
- read_en  in  1  high for the whole APB read transfer (setup and access cycles)
- write_en  in  1  high for exactly one cycle per APB write
- wdata  in  32  write data
- rdata  out  32  registered read data
- irq  out  1  level interrupt, registered

Behaviour:
- Clock and reset: one clock, pclk. Reset is synchronous, active-high on preset. At reset: FIFO empty, pointers and count 0, CTRL=0, THRESH=0, sticky flags 0, rdata=0, irq=0.
- Register map (byte offsets):
  - 0x000 DATA: write pushes; read pops.
  - 0x004 STATUS:
    - [0] empty, [1] full: RO.
    - [2] overflow, [3] underflow: sticky, W1C.
    - [15:8] count: RO, zero-extended.
  - 0x008 CTRL: [0] enable, [1] irq_en, [2] flush (self-clearing, always reads 0).
  - 0x00C THRESH: [7:0] RW.
  - Other offsets: read 0, writes ignored.
- Read timing:
  - Read start = read_en & ~read_en_d, where read_en_d is read_en delayed one cycle.
  - On read start, rdata is loaded from the addressed register and is valid from the next cycle (the APB access phase).
  - rdata holds until the next read start.
  - Exactly one pop per APB read, however long read_en stays high.
- DATA write:
  - enable=1 and not full: push wdata.
  - full: data dropped, overflow set.
  - enable=0: ignored, no flag change.
- DATA read:
  - enable=1 and not empty: rdata=head, pop.
  - empty: rdata=0, underflow set.
  - enable=0: rdata=0, no pop, no flag change.
- Flush: a CTRL write with bit2=1 empties the FIFO in that cycle (pointers and count to 0). Sticky flags are untouched. The other CTRL bits are still written by the same write.
- Count wrap: pointers wrap modulo depth; count ranges 0..depth.
- Threshold:
  - irq is asserted next cycle when irq_en=1 and count >= THRESH and THRESH != 0.
  - irq deasserts the cycle after the condition drops.
  - THRESH greater than depth: irq never asserts.
- Simultaneous events: the bus issues one transfer at a time, so a push and a pop never coincide. A W1C write and a new flag-setting event cannot coincide either.
- preset mid-transfer: state is reset immediately. A read in progress returns 0. The interface stage is not informed.

Optional Feature:
- Macro: CMSDK_APB3_EG_ID_REGS_EN.
- Defined: read-only ID registers at 0xFE0/0xFE4/0xFE8/0xFEC return 0x0000_0080, 0x0000_00B8, 0x0000_001B, 0x0000_0000. Writes to them are ignored.
- Undefined: these offsets read 0 like any other unmapped address.

Decomposition:
- Shared package holds:
  - register offset constants: DATA, STATUS, CTRL, THRESH, ID0..ID3;
  - STATUS and CTRL bit-index constants;
  - ID values.
- Natural sub-module: cmsdk_apb3_eg_sync_fifo (single clock, push/pop/flush, full/empty/count, synchronous active-high reset).

Test Plan:
- Reset, then read STATUS -> 0x0000_0001 (empty); rdata=0, irq=0.
- CTRL=0x1; write DATA 0xA5A5_0001..0xA5A5_0008 -> STATUS=0x0000_0802 (full, count 8). A 9th write sets overflow -> STATUS=0x0000_0806.
- Read DATA 8 times with read_en held for 3 cycles each -> returns 0xA5A5_0001..0008 in order, exactly one pop per read. The 9th read returns 0 and sets underflow (STATUS bit3).
- Write STATUS 0x0C -> both sticky flags clear. Push 3 words, then write CTRL=0x5 -> count 0, empty=1, CTRL reads back 0x1.
- THRESH=4, CTRL=0x3; push 4 words -> irq high the cycle after the 4th push; one pop -> irq low the cycle after the pop.
- With CMSDK_APB3_EG_ID_REGS_EN defined: read 0xFE4 -> 0x0000_00B8. Without it: read 0xFE4 -> 0.
